// File: rtl/alu_decode_issue_if.sv
// Handshake and bus bundle for the decode/issue stage.
//   instr_valid/instr_ready/instr : instruction word handshake (producer -> stage)
//   wb_valid/wb_rd/wb_data        : register writeback from the ALU result path
//   issue_valid/issue_ready       : issue slot handshake (stage -> ALU)
//   RS1/RS2/Funct3/Funct7/opcode/Imm_reg/Shamt/issue_rd : decoded bundle
//   illegal                       : one-cycle pulse per consumed unsupported word
interface alu_decode_issue_if #(
  parameter int unsigned WIDTH = 32
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             issue_valid;
  logic             issue_ready;
  logic [WIDTH-1:0] RS1;
  logic [WIDTH-1:0] RS2;
  logic [2:0]       Funct3;
  logic [6:0]       Funct7;
  logic [6:0]       opcode;
  logic [11:0]      Imm_reg;
  logic [4:0]       Shamt;
  logic [4:0]       issue_rd;
  logic             illegal;

  modport master (
    output instr_valid, instr, wb_valid, wb_rd, wb_data, issue_ready,
    input  instr_ready, issue_valid, RS1, RS2, Funct3, Funct7, opcode,
           Imm_reg, Shamt, issue_rd, illegal
  );

  modport slave (
    input  instr_valid, instr, wb_valid, wb_rd, wb_data, issue_ready,
    output instr_ready, issue_valid, RS1, RS2, Funct3, Funct7, opcode,
           Imm_reg, Shamt, issue_rd, illegal
  );
endinterface

// File: rtl/alu_decode_issue.sv
// Decode/issue stage for the integer ALU.
// Decodes RV32I R-type and I-type ALU words, reads operands from an internal
// register file (with writeback bypass), tracks pending destinations with busy
// bits and holds one registered issue slot.
//   clk : clock
//   rst : asynchronous reset, active low
//   bus : alu_decode_issue_if.slave (instruction, writeback and issue signals)
module alu_decode_issue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input logic              clk,
  input logic              rst,
  alu_decode_issue_if.slave bus
);

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_e;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  slot_e            state_q, state_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] rs2_q, rs2_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [6:0]       funct7_q, funct7_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [11:0]      imm_q, imm_d;
  logic [4:0]       shamt_q, shamt_d;
  logic [4:0]       rd_q, rd_d;
  logic             illegal_q, illegal_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd, src1, src2;
  logic       is_r, is_i, legal;
  logic [NREGS-1:0] busy_live;
  logic       hazard, slot_free, instr_ready, accept;
  logic [WIDTH-1:0] src1_val, src2_val;

  assign op   = bus.instr[6:0];
  assign rd   = bus.instr[11:7];
  assign f3   = bus.instr[14:12];
  assign src1 = bus.instr[19:15];
  assign src2 = bus.instr[24:20];
  assign f7   = bus.instr[31:25];
  assign is_r = (op == OP_R);
  assign is_i = (op == OP_I);

  always_comb begin
    legal = 1'b0;
    if (is_r) begin
      legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
    end else if (is_i) begin
      case (f3)
        3'b001:  legal = (f7 == 7'b0000000);
        3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        default: legal = 1'b1;
      endcase
    end
  end

  // A writeback landing this cycle releases its busy bit for the hazard check.
  always_comb begin
    busy_live = busy_q;
    if (bus.wb_valid) busy_live[bus.wb_rd] = 1'b0;
  end

  assign hazard      = busy_live[src1] | (is_r & busy_live[src2]) | busy_live[rd];
  assign slot_free   = (state_q == SLOT_EMPTY) | bus.issue_ready;
  assign instr_ready = slot_free & (~legal | ~hazard);
  assign accept      = bus.instr_valid & instr_ready;

  always_comb begin
    src1_val = rf_q[src1];
    if (src1 == '0) src1_val = '0;
    else if (bus.wb_valid && bus.wb_rd == src1) src1_val = bus.wb_data;
    src2_val = rf_q[src2];
    if (src2 == '0) src2_val = '0;
    else if (bus.wb_valid && bus.wb_rd == src2) src2_val = bus.wb_data;
  end

  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    opcode_d  = opcode_q;
    imm_d     = imm_q;
    shamt_d   = shamt_q;
    rd_d      = rd_q;
    illegal_d = 1'b0;
    busy_d    = busy_live;
    rf_d      = rf_q;

    if (bus.wb_valid && bus.wb_rd != '0) rf_d[bus.wb_rd] = bus.wb_data;

    if (state_q == SLOT_FULL && bus.issue_ready) state_d = SLOT_EMPTY;

    if (accept) begin
      if (legal) begin
        state_d  = SLOT_FULL;
        rs1_d    = src1_val;
        rs2_d    = is_r ? src2_val : '0;
        funct3_d = f3;
        funct7_d = f7;
        opcode_d = op;
        imm_d    = bus.instr[31:20];
        shamt_d  = bus.instr[24:20];
        rd_d     = rd;
        // Set after the writeback clear so a same-index set wins.
        if (rd != '0) busy_d[rd] = 1'b1;
      end else begin
        illegal_d = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SLOT_EMPTY;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      opcode_q  <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      busy_q    <= '0;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      opcode_q  <= opcode_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
      rf_q      <= rf_d;
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.issue_valid = (state_q == SLOT_FULL);
  assign bus.RS1         = rs1_q;
  assign bus.RS2         = rs2_q;
  assign bus.Funct3      = funct3_q;
  assign bus.Funct7      = funct7_q;
  assign bus.opcode      = opcode_q;
  assign bus.Imm_reg     = imm_q;
  assign bus.Shamt       = shamt_q;
  assign bus.issue_rd    = rd_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_decode_issue.sv
module tb_alu_decode_issue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_decode_issue_if #(.WIDTH(32)) bus ();

  alu_decode_issue #(.WIDTH(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  op;
    logic [11:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rd;
  } bundle_t;

  bundle_t     expq[$];
  int          checks = 0;
  int          failures = 0;

  // Reference architectural state
  logic [31:0] mregs [32];
  bit          mpending [32];
  bit          mfull;
  bit          mill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    if (w[6:0] == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20);
    if (w[6:0] == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int idx, input bit wbv, input int wbrd,
                                         input logic [31:0] wbd);
    if (idx == 0) return 32'd0;
    if (wbv && wbrd == idx) return wbd;
    return mregs[idx];
  endfunction

  function automatic bit m_waiting(input int idx, input bit wbv, input int wbrd);
    return (idx != 0) && mpending[idx] && !(wbv && wbrd == idx);
  endfunction

  // Reference model: predicts readiness, slot occupancy and illegal pulses,
  // and pushes the expected bundle for every legal accepted word.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = 32'd0;
        mpending[i] = 1'b0;
      end
      mfull = 1'b0;
      mill = 1'b0;
      expq.delete();
    end else begin
      logic [31:0] w;
      bit isr, lg, rdy, acc, wbv;
      int wbrd, s1, s2, rd;
      bundle_t b;
      w    = bus.instr;
      isr  = (w[6:0] == 7'h33);
      lg   = m_legal(w);
      wbv  = bus.wb_valid;
      wbrd = int'(bus.wb_rd);
      s1   = int'(w[19:15]);
      s2   = int'(w[24:20]);
      rd   = int'(w[11:7]);
      rdy  = (!mfull || bus.issue_ready) &&
             (!lg || !(m_waiting(s1, wbv, wbrd) || (isr && m_waiting(s2, wbv, wbrd)) ||
                       m_waiting(rd, wbv, wbrd)));
      chk("instr_ready", {31'd0, bus.instr_ready}, {31'd0, rdy});
      chk("issue_valid", {31'd0, bus.issue_valid}, {31'd0, mfull});
      chk("illegal", {31'd0, bus.illegal}, {31'd0, mill});
      acc = bus.instr_valid && rdy;
      if (acc && lg) begin
        b.rs1   = m_read(s1, wbv, wbrd, bus.wb_data);
        b.rs2   = isr ? m_read(s2, wbv, wbrd, bus.wb_data) : 32'd0;
        b.f3    = w[14:12];
        b.f7    = w[31:25];
        b.op    = w[6:0];
        b.imm   = w[31:20];
        b.shamt = w[24:20];
        b.rd    = w[11:7];
        expq.push_back(b);
      end
      mill = acc && !lg;
      if (acc && lg) mfull = 1'b1;
      else if (bus.issue_ready) mfull = 1'b0;
      if (wbv) mpending[wbrd] = 1'b0;
      if (acc && lg && rd != 0) mpending[rd] = 1'b1;
      if (wbv && wbrd != 0) mregs[wbrd] = bus.wb_data;
    end
  end

  // Monitor: whenever the slot is occupied it must match the oldest expected
  // bundle; the entry retires when the ALU side takes it.
  always @(negedge clk) begin
    if (rst && bus.issue_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_issue", 32'd1, 32'd0);
      end else begin
        chk("RS1", bus.RS1, expq[0].rs1);
        chk("RS2", bus.RS2, expq[0].rs2);
        chk("Funct3", {29'd0, bus.Funct3}, {29'd0, expq[0].f3});
        chk("Funct7", {25'd0, bus.Funct7}, {25'd0, expq[0].f7});
        chk("opcode", {25'd0, bus.opcode}, {25'd0, expq[0].op});
        chk("Imm_reg", {20'd0, bus.Imm_reg}, {20'd0, expq[0].imm});
        chk("Shamt", {27'd0, bus.Shamt}, {27'd0, expq[0].shamt});
        chk("issue_rd", {27'd0, bus.issue_rd}, {27'd0, expq[0].rd});
        if (bus.issue_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic step(input bit iv, input logic [31:0] w, input bit wbv,
                      input logic [4:0] wrd, input logic [31:0] wd, input bit ir);
    bus.instr_valid = iv;
    bus.instr       = w;
    bus.wb_valid    = wbv;
    bus.wb_rd       = wrd;
    bus.wb_data     = wd;
    bus.issue_ready = ir;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [6:0] f7, op;
    int k;
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    f7 = 7'($urandom);
    k  = $urandom_range(0, 9);
    if (k <= 3) begin
      op = 7'h33;
      f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end else if (k <= 6) begin
      op = 7'h13;
      if (f3 == 3'd1) f7 = 7'h00;
      else if (f3 == 3'd5) f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end else if (k == 7) begin
      op = 7'h33;
      f7 = 7'($urandom_range(1, 31));
    end else if (k == 8) begin
      op = 7'h13;
      f3 = 3'd1;
      f7 = 7'($urandom_range(1, 127));
    end else begin
      op = 7'($urandom);
      if (op == 7'h33 || op == 7'h13) op = 7'h73;
    end
    return {f7, r2, r1, f3, rd, op};
  endfunction

  initial begin
    bit last_acc;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;
    bus.issue_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    chk("rst_RS1", bus.RS1, 32'd0);
    chk("rst_RS2", bus.RS2, 32'd0);
    chk("rst_opcode", {25'd0, bus.opcode}, 32'd0);
    chk("rst_issue_rd", {27'd0, bus.issue_rd}, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    rst = 1'b1;

    // Operand read, RAW stall, bypass release
    step(0, 32'h0, 1, 5'd1, 32'd5, 1);
    step(0, 32'h0, 1, 5'd2, 32'd7, 1);
    step(1, 32'h002081B3, 0, 5'd0, 32'd0, 0);
    step(1, 32'h00118213, 0, 5'd0, 32'd0, 1);
    step(1, 32'h00118213, 1, 5'd3, 32'd12, 0);
    // Slot held while the ALU stalls, then back-to-back issue
    repeat (5) step(1, 32'h002082B3, 0, 5'd0, 32'd0, 0);
    step(1, 32'h002082B3, 0, 5'd0, 32'd0, 1);
    // Illegal words
    step(1, 32'h00000073, 0, 5'd0, 32'd0, 1);
    step(1, 32'h022081B3, 0, 5'd0, 32'd0, 1);
    step(0, 32'h0, 1, 5'd5, 32'h63, 1);
    step(0, 32'h0, 1, 5'd4, 32'h44, 1);
    // x0 writeback ignored and never bypassed; x0 never busy
    step(1, 32'h000002B3, 1, 5'd0, 32'hFFFF_FFFF, 1);
    step(1, 32'h00208033, 0, 5'd0, 32'd0, 1);
    step(1, 32'h00208033, 0, 5'd0, 32'd0, 1);
    step(0, 32'h0, 0, 5'd0, 32'd0, 1);

    // Asynchronous reset while FULL with x3 pending
    step(1, 32'h002081B3, 0, 5'd0, 32'd0, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    chk("async_RS1", bus.RS1, 32'd0);
    chk("async_issue_rd", {27'd0, bus.issue_rd}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    step(1, 32'h00118213, 0, 5'd0, 32'd0, 1);
    step(1, 32'h00008333, 0, 5'd0, 32'd0, 1);
    step(0, 32'h0, 0, 5'd0, 32'd0, 1);

    // Randomized traffic
    last_acc = 1'b0;
    bus.instr_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!bus.instr_valid || last_acc) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.instr_valid = 1'b1;
          bus.instr = rand_instr();
        end else begin
          bus.instr_valid = 1'b0;
        end
      end
      bus.wb_valid    = ($urandom_range(0, 2) == 0);
      bus.wb_rd       = 5'($urandom_range(0, 7));
      bus.wb_data     = $urandom();
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      last_acc = bus.instr_valid && bus.instr_ready;
      @(posedge clk);
      #1;
    end

    repeat (4) step(0, 32'h0, 0, 5'd0, 32'd0, 1);
    chk("drain_empty", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_decode_issue.md
Name: alu_decode_issue

Overview:
- Decode/issue stage that produces the operand and field bundle consumed by the integer ALU.
- Accepts 32-bit RV32I instruction words on a valid/ready handshake and decodes the R-type (opcode 0110011) and I-type ALU (opcode 0010011) formats.
- Reads operands from an internal 32x WIDTH register file, which is written back from the ALU result path.
- Enforces RAW/WAW hazards with a busy-bit scoreboard and presents one registered issue slot to the ALU.

Parameters:
- WIDTH, 32, data/register width.
- NREGS, 32, number of architectural registers (index width 5).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset; asserted when 0.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  instruction accepted this cycle when high together with instr_valid.
- instr  in  32  RV32I instruction word.
- wb_valid  in  1  register writeback strobe.
- wb_rd  in  5  writeback destination index.
- wb_data  in  WIDTH  writeback value.
- issue_valid  out  1  issue slot holds a decoded instruction.
- issue_ready  in  1  ALU side takes the slot.
- RS1  out  WIDTH  source operand 1.
- RS2  out  WIDTH  source operand 2; 0 for I-type.
- Funct3  out  3  instr[14:12].
- Funct7  out  7  instr[31:25].
- opcode  out  7  instr[6:0].
- Imm_reg  out  12  instr[31:20].
- Shamt  out  5  instr[24:20].
- issue_rd  out  5  destination index, instr[11:7].
- illegal  out  1  one-cycle pulse when an unsupported word is consumed.

Behaviour:
- Reset (rst=0, asynchronous):
  - issue_valid=0; all bundle outputs and issue_rd = 0; illegal=0.
  - All busy bits 0; all registers 0.
  - Anything in flight is dropped.
- Slot state machine, two states:
  - EMPTY: issue_valid=0.
  - FULL: issue_valid=1.
  - FULL -> EMPTY on issue_ready with no accept in the same cycle.
  - FULL -> FULL on issue_ready plus a new accept (back-to-back, one instruction per cycle).
  - EMPTY -> FULL on accept of a legal instruction.
- slot_free = !issue_valid | issue_ready.
- Hazard sources:
  - src1 = instr[19:15] for both formats.
  - src2 = instr[24:20] for R-type only.
  - A source is hazardous if its busy bit is set and it is not cleared by a writeback this cycle.
  - rd is hazardous under the same rule (WAW).
- instr_ready = slot_free & !hazard.
  - For illegal words: instr_ready = slot_free, with no hazard check.
  - instr_ready may depend on instr.
- Accept (instr_valid & instr_ready):
  - Bundle is registered; issue_valid rises the next cycle (latency 1).
  - Operands are captured at accept.
  - Bypass: if wb_valid and wb_rd equals a source index (non-zero), wb_data is used instead of the register file.
- Legality:
  - R-type: Funct7 must be 0000000 or 0100000.
  - I-type with funct3=001: instr[31:25] must be 0.
  - I-type with funct3=101: instr[31:25] must be 0000000 or 0100000.
  - Any other opcode is illegal.
  - An illegal word is consumed: illegal=1 for one cycle, no issue, no busy change.
- Scoreboard:
  - On accept of a legal instruction with rd != 0, busy[rd] is set.
  - wb_valid clears busy[wb_rd].
  - Same-index set and clear in one cycle: set wins.
- Register file:
  - Written on wb_valid when wb_rd != 0, regardless of busy state.
  - x0 always reads 0, never becomes busy, and is never hazardous.
- While FULL and issue_ready=0, all issue outputs are held stable.
- illegal is registered and pulses for exactly one cycle per illegal accept.

Test Plan:
- Reset, then writeback x1=5, x2=7; send 0x002081B3 (add x3,x1,x2) -> next cycle: issue_valid=1, RS1=5, RS2=7, Funct3=0, Funct7=0, opcode=0x33, issue_rd=3; busy[3]=1.
- Follow with 0x00118213 (addi x4,x3,1), no writeback -> instr_ready=0. Then wb_rd=3, wb_data=12 -> accepted that cycle; next cycle: RS1=12, Imm_reg=1, RS2=0, issue_rd=4.
- Hold issue_ready=0 for 5 cycles with a second legal word pending -> outputs constant, instr_ready=0. Raise issue_ready -> new bundle the next cycle, no gap.
- Send 0x00000073 (ecall) and 0x022081B3 (Funct7=1) -> each consumed with a one-cycle illegal pulse; issue_valid stays 0; busy unchanged.
- wb_rd=0, wb_data=0xFFFFFFFF, then add x5,x0,x0 (0x000002B3) -> RS1=0, RS2=0. add x0,x1,x2 issues with busy[0] still 0.
- Drive rst=0 mid-cycle while FULL with busy[3]=1 -> issue_valid=0 and busy cleared immediately (no clock edge). After release, a read of x1 returns 0.
